// File: rtl/tmds_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tmds_decoder: TMDS lane word aligner (bit-slip on control tokens) + decoder
// Rev 1.0
// ----------------------------------------------------------------------------
module tmds_decoder #(
  parameter int LOCK_COUNT  = 8,
  parameter int SEARCH_WAIT = 4096,
  parameter int MAX_GAP     = 2048
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [9:0] din,
  output logic       Video,
  output logic [1:0] Cntrl,
  output logic [7:0] Color,
  output logic       locked,
  output logic [3:0] slip_offset
);

  localparam int TOK_W = $clog2(LOCK_COUNT + 1);
  localparam int TMR_W = $clog2(SEARCH_WAIT);
  localparam int GAP_W = $clog2(MAX_GAP + 1);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state;
  logic [9:0]       prev;
  logic [9:0]       w;
  logic [9:0]       w_next;
  logic [3:0]       off;
  logic [3:0]       off_next;
  logic [TOK_W-1:0] tok_cnt;
  logic [TMR_W-1:0] tmr;
  logic [GAP_W-1:0] gap;
  logic             blank;
  logic             is_tok;
  logic [1:0]       tok_val;
  logic [7:0]       d;
  logic [7:0]       dec;
  logic             lock_hit;
  logic             timeout;
  logic             gap_hit;
  logic             next_locked;

  // Bit 0 of the window is the earliest serial bit, so the aligned word is a right shift.
  assign w_next   = 10'({din, prev} >> off);
  assign off_next = (off == 4'd9) ? 4'd0 : off + 4'd1;

  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    case (w)
      10'b1101010100: tok_val = 2'b00;
      10'b0010101011: tok_val = 2'b01;
      10'b0101010100: tok_val = 2'b10;
      10'b1010101011: tok_val = 2'b11;
      default:        is_tok  = 1'b0;
    endcase
  end

  always_comb begin
    d      = w[9] ? ~w[7:0] : w[7:0];
    dec    = 8'd0;
    dec[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  // The word right after an offset change was aligned with the old offset; blank skips it.
  assign lock_hit    = (state == SEARCH) && !blank && is_tok &&
                       (tok_cnt == TOK_W'(LOCK_COUNT - 1));
  assign timeout     = (state == SEARCH) && (tmr == TMR_W'(SEARCH_WAIT - 1));
  assign gap_hit     = (state == LOCKED) && !is_tok && (gap == GAP_W'(MAX_GAP - 1));
  assign next_locked = (state == SEARCH) ? lock_hit : !gap_hit;
  assign slip_offset = off;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state   <= SEARCH;
      prev    <= 10'd0;
      w       <= 10'd0;
      off     <= 4'd0;
      tok_cnt <= '0;
      tmr     <= '0;
      gap     <= '0;
      blank   <= 1'b0;
      locked  <= 1'b0;
      Video   <= 1'b0;
      Cntrl   <= 2'b00;
      Color   <= 8'd0;
    end else begin
      prev   <= din;
      w      <= w_next;
      blank  <= 1'b0;
      locked <= next_locked;
      case (state)
        SEARCH: begin
          if (lock_hit) begin
            state   <= LOCKED;
            tmr     <= '0;
            tok_cnt <= '0;
            gap     <= '0;
          end else if (timeout) begin
            off     <= off_next;
            tmr     <= '0;
            tok_cnt <= '0;
            blank   <= 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
            if (!blank) begin
              tok_cnt <= is_tok ? tok_cnt + 1'b1 : '0;
            end
          end
        end
        LOCKED: begin
          if (gap_hit) begin
            state   <= SEARCH;
            off     <= off_next;
            gap     <= '0;
            tmr     <= '0;
            tok_cnt <= '0;
            blank   <= 1'b1;
          end else begin
            gap <= is_tok ? '0 : gap + 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase

      if (!next_locked) begin
        Video <= 1'b0;
        Cntrl <= 2'b00;
        Color <= 8'd0;
      end else if (is_tok) begin
        Video <= 1'b0;
        Cntrl <= tok_val;
        Color <= 8'd0;
      end else begin
        Video <= 1'b1;
        Color <= dec;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tmds_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tmds_decoder: directed bench for tmds_decoder. Rev 1.0
// ----------------------------------------------------------------------------
module tb_tmds_decoder;

  localparam logic [9:0] T00  = 10'b1101010100;
  localparam logic [9:0] T01  = 10'b0010101011;
  localparam logic [9:0] T10  = 10'b0101010100;
  localparam logic [9:0] T11  = 10'b1010101011;
  localparam logic [9:0] D100 = 10'h100;
  localparam logic [9:0] D200 = 10'h200;

  logic       clock  = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] din    = 10'h3FF;
  logic       Video;
  logic [1:0] Cntrl;
  logic [7:0] Color;
  logic       locked;
  logic [3:0] slip_offset;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = -1;
  logic [9:0] last_w = T00;

  always #5 clock = ~clock;

  tmds_decoder #(
    .LOCK_COUNT (8),
    .SEARCH_WAIT(4096),
    .MAX_GAP    (2048)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .din        (din),
    .Video      (Video),
    .Cntrl      (Cntrl),
    .Color      (Color),
    .locked     (locked),
    .slip_offset(slip_offset)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".Video"}, Video, 0);
    chk({tag, ".Cntrl"}, Cntrl, 0);
    chk({tag, ".Color"}, Color, 0);
    chk({tag, ".locked"}, locked, 0);
    chk({tag, ".slip"}, slip_offset, 0);
  endtask

  task automatic step(input logic [9:0] v);
    din = v;
    @(posedge clock);
    cyc++;
    #1;
  endtask

  // Serial stream delayed by 3 bits: each din carries the previous word's top 3 bits first.
  task automatic step_sh(input logic [9:0] v);
    step({v[6:0], last_w[9:7]});
    last_w = v;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    din    = 10'h3FF;
    repeat (4) begin
      @(posedge clock);
      #1;
      chk_idle("reset");
    end
    resetn = 1'b1;
    cyc    = -1;
  endtask

  initial begin
    // Aligned stream, token values, Cntrl hold and loss of lock
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(T00);
      if (cyc == 0) chk_idle("first_edge");
      if (cyc == 8) chk("pre_lock.locked", locked, 0);
      if (cyc == 9) begin
        chk("lock_edge.locked", locked, 1);
        chk("lock_edge.Cntrl", Cntrl, 0);
        chk("lock_edge.Video", Video, 0);
      end
    end
    step(D100);
    step(D200);
    step(T01);
    chk("d100.Video", Video, 1);
    chk("d100.Color", Color, 8'h00);
    chk("d100.Cntrl", Cntrl, 0);
    step(T10);
    chk("d200.Video", Video, 1);
    chk("d200.Color", Color, 8'hFF);
    step(T11);
    chk("tok01.Cntrl", Cntrl, 2'b01);
    chk("tok01.Video", Video, 0);
    chk("tok01.Color", Color, 0);
    step(D100);
    chk("tok10.Cntrl", Cntrl, 2'b10);
    chk("tok10.Video", Video, 0);
    step(D100);
    chk("tok11.Cntrl", Cntrl, 2'b11);
    chk("tok11.Video", Video, 0);
    while (cyc < 2070) begin
      step(D100);
      if (cyc == 23) begin
        chk("hold.Video", Video, 1);
        chk("hold.Cntrl", Cntrl, 2'b11);
        chk("hold.Color", Color, 8'h00);
      end
      if (cyc == 2069) chk("gap_pre.locked", locked, 1);
      if (cyc == 2070) begin
        chk("gap_drop.locked", locked, 0);
        chk("gap_drop.slip", slip_offset, 1);
        chk("gap_drop.Video", Video, 0);
        chk("gap_drop.Cntrl", Cntrl, 0);
        chk("gap_drop.Color", Color, 0);
      end
    end

    // Stream delayed by 3 bits: search must walk 0 -> 3
    do_reset();
    last_w = T00;
    while (cyc < 12298) begin
      step_sh(T00);
      if (cyc == 4094) begin
        chk("sh_4094.slip", slip_offset, 0);
        chk("sh_4094.locked", locked, 0);
      end
      if (cyc == 4095)  chk("sh_4095.slip", slip_offset, 1);
      if (cyc == 8190)  chk("sh_8190.slip", slip_offset, 1);
      if (cyc == 8191)  chk("sh_8191.slip", slip_offset, 2);
      if (cyc == 12286) chk("sh_12286.slip", slip_offset, 2);
      if (cyc == 12287) chk("sh_12287.slip", slip_offset, 3);
      if (cyc == 12295) chk("sh_pre.locked", locked, 0);
      if (cyc == 12296) begin
        chk("sh_lock.locked", locked, 1);
        chk("sh_lock.slip", slip_offset, 3);
        chk("sh_lock.Cntrl", Cntrl, 0);
      end
    end
    step_sh(D100);
    step_sh(D200);
    step_sh(T00);
    chk("sh_d100.Video", Video, 1);
    chk("sh_d100.Color", Color, 8'h00);
    step_sh(T00);
    chk("sh_d200.Video", Video, 1);
    chk("sh_d200.Color", Color, 8'hFF);
    step_sh(T00);
    chk("sh_tok.Video", Video, 0);
    chk("sh_tok.locked", locked, 1);

    // 8th token lands on the SEARCH timeout cycle: lock wins
    do_reset();
    while (cyc < 4085) step(D100);
    while (cyc < 4097) begin
      step(T00);
      if (cyc == 4094) begin
        chk("col_pre.locked", locked, 0);
        chk("col_pre.slip", slip_offset, 0);
      end
      if (cyc == 4095) begin
        chk("col_hit.locked", locked, 1);
        chk("col_hit.slip", slip_offset, 0);
      end
      if (cyc == 4097) begin
        chk("col_post.locked", locked, 1);
        chk("col_post.slip", slip_offset, 0);
      end
    end

    // Reset while locked is honoured on the next edge
    resetn = 1'b0;
    step(T00);
    chk("midrst.locked", locked, 0);
    chk("midrst.Video", Video, 0);
    chk("midrst.Cntrl", Cntrl, 0);
    resetn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
